// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: opcode/flag inputs and datapath control strobes of the multicycle sequencer
interface mc_ctrl_if #(parameter int OP_W = 6);
  logic [OP_W-1:0] op;
  logic            zero;
  logic            mem_ready;
  logic            pc_en;
  logic            irwrite;
  logic            iord;
  logic            memwrite;
  logic            regwrite;
  logic            regdst;
  logic            memtoreg;
  logic            alusrca;
  logic [1:0]      alusrcb;
  logic [1:0]      aluop;
  logic [1:0]      pcsrc;
  logic            retire;
  logic            err;
  logic [3:0]      state;
  modport master (
    output op, zero, mem_ready,
    input  pc_en, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, aluop, pcsrc, retire, err, state
  );
  modport slave (
    input  op, zero, mem_ready,
    output pc_en, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, aluop, pcsrc, retire, err, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS Moore sequencer with memory-wait watchdog; define MC_CTRL_BNE_EN to add bne
module mc_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int OP_W           = 6
) (
  input logic     clk,
  input logic     reset,
  mc_ctrl_if.slave bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    JEX     = 4'd10,
    ADDIWB  = 4'd11,
    BNEEX   = 4'd12,
    ERROR   = 4'd15
  } state_t;
  state_t        state_q, state_d, s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, waiting, timeout;
  // next state, saturating wait counter and sticky error
  always_comb begin
    waiting = state_q == FETCH || state_q == MEMRD || state_q == MEMWR;
    timeout = TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES) && !bus.mem_ready;
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : timeout ? ERROR : FETCH;
      DECODE: begin
        state_d = ERROR;
        if (bus.op == OP_W'(6'b000000)) state_d = RTYPEEX;
        if (bus.op == OP_W'(6'b100011) || bus.op == OP_W'(6'b101011)) state_d = MEMADR;
        if (bus.op == OP_W'(6'b000100)) state_d = BEQEX;
        if (bus.op == OP_W'(6'b001000)) state_d = ADDIEX;
        if (bus.op == OP_W'(6'b000010)) state_d = JEX;
`ifdef MC_CTRL_BNE_EN
        if (bus.op == OP_W'(6'b000101)) state_d = BNEEX;
`endif
      end
      MEMADR:  state_d = bus.op == OP_W'(6'b101011) ? MEMWR : MEMRD;
      MEMRD:   state_d = bus.mem_ready ? MEMWB : timeout ? ERROR : MEMRD;
      MEMWR:   state_d = bus.mem_ready ? FETCH : timeout ? ERROR : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX: state_d = FETCH;
`ifdef MC_CTRL_BNE_EN
      BNEEX:   state_d = FETCH;
`endif
      default: state_d = ERROR;
    endcase
    cnt_d = state_d != state_q ? '0 :
            (waiting && !bus.mem_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    err_d = state_d == ERROR;
  end
  // state, counter and error registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // Moore decode of datapath controls; reset forces FETCH selects with strobes off
  always_comb begin
    s            = reset ? FETCH : state_q;
    bus.pc_en    = 1'b0;
    bus.irwrite  = 1'b0;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.regwrite = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluop    = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.retire   = 1'b0;
    case (s)
      FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready && !reset;
        bus.pc_en   = bus.mem_ready && !reset;
      end
      DECODE:  bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD:   bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        bus.retire   = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
        bus.retire   = bus.mem_ready;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      RTYPEWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        bus.retire   = 1'b1;
      end
      BEQEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        bus.pc_en   = bus.zero;
        bus.retire  = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      BNEEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        bus.pc_en   = !bus.zero;
        bus.retire  = 1'b1;
      end
`endif
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      ADDIWB: begin
        bus.regwrite = 1'b1;
        bus.retire   = 1'b1;
      end
      JEX: begin
        bus.pcsrc  = 2'b10;
        bus.pc_en  = 1'b1;
        bus.retire = 1'b1;
      end
      default: ;
    endcase
    bus.err   = err_q && !reset;
    bus.state = s;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle sequencer for the MIPS datapath. It replaces the single-cycle mainDec with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath strobe and mux select. Memory accesses use a ready handshake with a wait-timeout watchdog. It sits between the instruction register opcode/zero flag and the shared instruction/data memory, register file and ALU; aluop feeds the existing aluDec.

Parameters:
TIMEOUT_CYCLES, 15, consecutive not-ready cycles tolerated in a memory wait state before ERROR; 0 disables the watchdog.
OP_W, 6, opcode width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  OP_W  opcode from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
pc_en  out  1  PC load enable (pcwrite | branch&zero)
irwrite  out  1  instruction register load
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  memory write request
regwrite  out  1  register file write
regdst  out  1  0=rt, 1=rd
memtoreg  out  1  0=ALUOut, 1=mem data
alusrca  out  1  0=PC, 1=regA
alusrcb  out  2  00=regB, 01=4, 10=signimm, 11=signimm<<2
aluop  out  2  00=add, 01=sub, 10=funct
pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
retire  out  1  one-cycle pulse on final cycle of each instruction
err  out  1  sticky error flag
state  out  4  current state code (debug)

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, JEX 10, ADDIWB 11, BNEEX 12, ERROR 15.
- Reset has priority over all events, including mid-instruction and mid-wait. On reset: state=FETCH, wait counter=0, err=0. While reset is high, pc_en, irwrite, memwrite, regwrite and retire are 0; the other outputs show their FETCH values.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. If mem_ready=1, assert irwrite=1 and pc_en=1, then go to DECODE. If mem_ready=0, hold state with strobes at 0.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 000000 -> RTYPEEX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> ERROR
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, retire=1. Go to FETCH.
- MEMWR: iord=1, memwrite=1, held until mem_ready. On the ready cycle retire=1 and go to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Go to RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, retire=1. Go to FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pc_en=zero, retire=1. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, retire=1. Go to FETCH.
- JEX: pcsrc=10, pc_en=1, retire=1. Go to FETCH.
- ERROR: all strobes 0, err=1. Stays in ERROR until reset.
- Unlisted outputs are 0 in every state. Selects are don't-care internally, but RTL drives them 0.
- Wait counter:
  - Counts in FETCH, MEMRD and MEMWR while mem_ready=0.
  - Clears on any state change.
  - If the counter equals TIMEOUT_CYCLES (nonzero) while mem_ready is still 0, the next state is ERROR.
  - A mem_ready on the same cycle the limit is reached wins: normal progress, no error.
  - Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.
- All state, counter and err registers are updated on the clk rising edge. Outputs are combinational from state, mem_ready and zero only.
- CPI with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Optional Feature:
MC_CTRL_BNE_EN:
- Defined: op 000101 in DECODE goes to BNEEX. BNEEX is identical to BEQEX except pc_en=~zero.
- Undefined: op 000101 goes to ERROR and state code 12 is never reached.

Test Plan:
1. reset high 2 cycles, then low, mem_ready=1, op=100011 (lw) -> state 0,1,2,3,4. irwrite/pc_en high only in cycle 1. regwrite=memtoreg=1 and retire=1 in cycle 5, then state=0.
2. op=000100, zero=1 then zero=0 -> BEQEX reached in cycle 3 each time, pcsrc=01. pc_en=1 on the first pass and 0 on the second; retire=1 both times.
3. FETCH with mem_ready=0 for 3 cycles then 1 (TIMEOUT_CYCLES=15) -> state stays 0 for 4 cycles. irwrite=1 only on the 4th cycle, err=0.
4. TIMEOUT_CYCLES=4, sw in MEMWR with mem_ready held 0 -> memwrite=1 for 5 cycles, then state=15 and err=1. Raising mem_ready afterwards has no effect; reset returns to state 0 with err=0.
5. op=111111 -> DECODE then ERROR (15), no regwrite/memwrite/pc_en ever asserted. Repeat with op=000101 and MC_CTRL_BNE_EN defined, zero=0 -> state 12 with pc_en=1.
6. reset asserted while in RTYPEEX -> next cycle state=0, regwrite never pulses for the aborted instruction.
